uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between N_REQ byte-stream requesters.
- Selects requesters round-robin and locks the grant for a whole message, from first byte to req_last.
- Forces the grant to release after a burst cap or an idle timeout, so no requester can starve the others.
- Sits between the requesters and uart_tx; drives tx_data/tx_valid and observes tx_ready.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max bytes per grant before forced release (1..255).
- IDLE_TO, 64, cycles a granted requester may hold req_valid low before forced release (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  N_REQ  marks final byte of a message; qualified by req_valid.
- req_ready  output  N_REQ  byte accepted for requester i when req_valid[i] & req_ready[i].
- grant  output  N_REQ  one-hot current owner; all-zero when idle.
- busy  output  1  high while a grant is held.
- tx_data  output  8  byte to uart_tx.
- tx_valid  output  1  byte valid to uart_tx.
- tx_ready  input  1  uart_tx can accept a byte; a byte transfers on a cycle with tx_valid & tx_ready.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, busy=0, rr_ptr=0, beat_cnt=0, idle_cnt=0.
  - Combinational outputs also reset: tx_valid=0, req_ready=0, tx_data=8'h00.
- State IDLE:
  - grant=0; tx_valid=0; req_ready=0; tx_data=8'h00.
  - If any req_valid: winner = first set bit scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - Next cycle: state=LOCK, grant=onehot(winner), beat_cnt=0, idle_cnt=0.
  - Latency: req_valid rising at edge t gives grant and tx_valid at edge t+1. No byte is transferred in the IDLE cycle.
- State LOCK, owner g (combinational):
  - tx_data=req_data[g].
  - tx_valid=req_valid[g].
  - req_ready[g]=tx_ready; all other req_ready=0.
  - busy=1.
- Beat = tx_valid & tx_ready. On a beat: beat_cnt+1, idle_cnt=0.
- While req_valid[g]=0: idle_cnt+1 per cycle.
- Release: next state=IDLE, grant=0, rr_ptr=(g+1) mod N_REQ. Release happens when any of these holds:
  - (a) beat with req_last[g]=1;
  - (b) beat making beat_cnt==MAX_BURST;
  - (c) idle_cnt reaches IDLE_TO.
- After release, one IDLE cycle always separates grants. The same requester may win again only if no other requester is valid.
- Requests from non-owners are ignored while in LOCK; their req_ready stays 0 and their data is not consumed.
- Simultaneous (b)+(a): single release, no double counting.
- Release (c) never coincides with a beat, because idle_cnt increments only when req_valid[g]=0.
- Forced release (b)/(c) mid-message: the requester keeps its remaining bytes and re-arbitrates. Message framing across grants is the requester's responsibility.
- rr_ptr wraps N_REQ-1 → 0.
- Counters are 8-bit saturating-free; their bounds are guaranteed by the release rules.
- Async reset mid-LOCK: immediate return to reset values; any byte already accepted by uart_tx completes on the line regardless.
- No output may change during LOCK except on a beat, a release, or an input change of requester g.

Test Plan:
1. Req 0 sends 3 bytes 8'h15, 8'h4d, 8'h03 (last on 3rd), tx_ready pulsing per byte → tx_data sequence 15, 4d, 03; grant=0001 for exactly 3 beats; then IDLE; rr_ptr=1.
2. Reqs 0 and 2 valid together from reset, one byte each with last=1 → grant 0001 then 0100; output bytes in order req0, req2; one IDLE cycle between grants.
3. Req 1 streams 20 bytes without last, MAX_BURST=16; req 3 valid → 16 bytes from req1, release, req3 granted; req1 later resumes with byte 17.
4. Req 2 granted, sends 1 byte, then drops req_valid for IDLE_TO=64 cycles → release at cycle 64 of idle; grant=0; req_ready[2]=0 afterwards.
5. Reset pulse (rst=0 for 10 ns) asserted mid-LOCK after 2 of 5 bytes → grant=0, tx_valid=0 immediately; after rst=1, arbitration restarts from rr_ptr=0.
6. rr_ptr=3; reqs 0 and 3 valid, one byte each → req 3 served first, then req 0 (wrap); rr_ptr ends at 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte-stream requesters.
// A grant is held for a whole message, with forced release after a burst cap or an idle timeout.
module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 16,
   parameter int IDLE_TO   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready
);

   localparam int         IW          = $clog2(N_REQ);
   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
   localparam logic [7:0] IDLE_TO_C   = 8'(IDLE_TO);

   typedef enum logic {IDLE, LOCK} state_e;

   state_e            state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic [7:0]        idle_cnt_q, idle_cnt_d;

   logic              found;
   logic [IW-1:0]     winner;
   logic [IW-1:0]     cand;
   int                idx;
   logic              owner_valid;
   logic              owner_last;
   logic              beat;
   logic              rel;
   logic [7:0]        beat_cnt_inc;
   logic [7:0]        idle_cnt_inc;
   logic [IW-1:0]     owner_next;
   logic [IW+2:0]     data_base;

   // Round-robin scan: first valid requester at or after rr_ptr, wrapping at N_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = IW'(idx);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign owner_valid  = req_valid[owner_q];
   assign owner_last   = req_last[owner_q];
   assign beat         = (state_q == LOCK) && owner_valid && tx_ready;
   assign beat_cnt_inc = beat_cnt_q + 8'd1;
   assign idle_cnt_inc = idle_cnt_q + 8'd1;
   assign owner_next   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

   // Idle timeout only advances while the owner has nothing to send, so it can never
   // coincide with a beat; last and burst cap on the same beat collapse into one release.
   assign rel = (state_q == LOCK) &&
                ((beat && (owner_last || beat_cnt_inc == MAX_BURST_C)) ||
                 (!owner_valid && idle_cnt_inc == IDLE_TO_C));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      idle_cnt_d = idle_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d         = LOCK;
               owner_d         = winner;
               grant_d         = '0;
               grant_d[winner] = 1'b1;
               beat_cnt_d      = '0;
               idle_cnt_d      = '0;
            end
         end
         LOCK: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_inc;
               idle_cnt_d = '0;
            end else if (!owner_valid) begin
               idle_cnt_d = idle_cnt_inc;
            end
            if (rel) begin
               state_d    = IDLE;
               grant_d    = '0;
               rr_ptr_d   = owner_next;
               beat_cnt_d = '0;
               idle_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      req_ready = '0;
      data_base = {owner_q, 3'b000};
      if (state_q == LOCK) begin
         tx_data            = req_data[data_base +: 8];
         tx_valid           = owner_valid;
         req_ready[owner_q] = tx_ready;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == LOCK);

endmodule
